// File: rtl/memory_map.sv
// memory_map: shared address map macros/constants, exception codes and FSM encodings for data_bus_ctrl (LED register enabled by DATA_BUS_LED_EN)
`ifndef INITIAL_PC
`define INITIAL_PC 64'h0000_0000_8000_0000
`endif
`ifndef MEM_END
`define MEM_END 64'h0000_0000_8000_2000
`endif
`ifndef LED_ADDR
`define LED_ADDR 64'h0000_0000_1000_0000
`endif
package memory_map;
  localparam logic [63:0] INITIAL_PC = `INITIAL_PC;
  localparam logic [63:0] MEM_END = `MEM_END;
  localparam logic [63:0] LED_ADDR = `LED_ADDR;
  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_RANGE = 2'b01;
  localparam logic [1:0] EXC_MISALIGN = 2'b10;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
endpackage

// File: rtl/data_bus_ctrl_if.sv
// data_bus_ctrl_if: request/response bus between a master and data_bus_ctrl
interface data_bus_ctrl_if #(parameter int DATA_W = 64, parameter int ADDR_W = 64);
  logic req, we, ready, rvalid, exception;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata;
  logic [DATA_W/8-1:0] be;
  logic [1:0] exc_code;
  logic [7:0] led;
  modport master (output req, we, addr, wdata, be, input ready, rvalid, rdata, exception, exc_code, led);
  modport slave (input req, we, addr, wdata, be, output ready, rvalid, rdata, exception, exc_code, led);
endinterface

// File: rtl/data_bus_ram.sv
// data_bus_ram: single-port word RAM with byte-enable write and registered read, contents never reset
module data_bus_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  always_comb rdata_d = (en && !we) ? mem[addr] : rdata_q;
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    for (int i = 0; i < DATA_W / 8; i++)
      if (en && we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/data_bus_ctrl.sv
// data_bus_ctrl: IDLE->ACCESS->RESP bus controller over data_bus_ram with range/alignment checks; DATA_BUS_LED_EN adds an LED register
module data_bus_ctrl
  import memory_map::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int DEPTH = 1024,
  parameter logic [ADDR_W-1:0] BASE = ADDR_W'(`INITIAL_PC)
) (
  input logic clk,
  input logic rst,
  data_bus_ctrl_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int OB = $clog2(BYTES);
  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] SPAN = (ADDR_W + 1)'(DEPTH * BYTES);
  logic [1:0] state_q, state_d, exc_q, exc_d;
  logic we_q, we_d, led_hit_q, led_hit_d;
  logic [ADDR_W-1:0] addr_q, addr_d, off;
  logic [DATA_W-1:0] wdata_q, wdata_d, ram_rdata;
  logic [BYTES-1:0] be_q, be_d;
  logic accept, mis, in_range, hit, ram_en, rvalid;
  logic [7:0] led;
  always_comb begin
    accept = bus.req && state_q == IDLE;
    mis = (bus.addr & ADDR_W'(BYTES - 1)) != '0;
    in_range = bus.addr >= BASE && ({1'b0, bus.addr} - {1'b0, BASE}) < SPAN;
    state_d = accept ? ACCESS : state_q == ACCESS ? RESP : IDLE;
    we_d = accept ? bus.we : we_q;
    addr_d = accept ? bus.addr : addr_q;
    wdata_d = accept ? bus.wdata : wdata_q;
    be_d = accept ? bus.be : be_q;
    exc_d = accept ? (mis ? EXC_MISALIGN : (in_range || hit) ? EXC_NONE : EXC_RANGE) : exc_q;
    led_hit_d = accept ? hit && !mis : led_hit_q;
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    we_q <= we_d;
    addr_q <= addr_d;
    wdata_q <= wdata_d;
    be_q <= be_d;
    exc_q <= exc_d;
    led_hit_q <= led_hit_d;
  end
`ifdef DATA_BUS_LED_EN
  logic [7:0] led_q, led_d;
  always_comb led_d = (state_q == ACCESS && led_hit_q && we_q && be_q[0]) ? wdata_q[7:0] : led_q;
  always_ff @(posedge clk) led_q <= rst ? '0 : led_d;
  assign led = led_q;
  assign hit = bus.addr == ADDR_W'(`LED_ADDR);
`else
  assign led = '0;
  assign hit = 1'b0;
`endif
  assign ram_en = state_q == ACCESS && exc_q == EXC_NONE && !led_hit_q && !rst;
  assign off = addr_q - BASE;
  data_bus_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk), .en(ram_en), .we(we_q), .be(be_q), .addr(AW'(off >> OB)),
    .wdata(wdata_q), .rdata(ram_rdata)
  );
  assign rvalid = state_q == RESP;
  assign bus.ready = state_q == IDLE;
  assign bus.rvalid = rvalid;
  assign bus.exception = rvalid && exc_q != EXC_NONE;
  assign bus.exc_code = rvalid ? exc_q : EXC_NONE;
  assign bus.rdata = (rvalid && !we_q && exc_q == EXC_NONE) ? (led_hit_q ? DATA_W'(led) : ram_rdata) : '0;
  assign bus.led = led;
endmodule
